s2p_frame_ctrl: RTL and testbench
=================================

Name: s2p_frame_ctrl

Overview:
Controller that sequences a serial-to-parallel shift datapath. It qualifies incoming serial bits, counts them into DATA_WIDTH-bit words, and aligns word boundaries on a start-of-frame marker. Completed words are presented on a single-entry valid/ready output register, with sticky overflow reporting. It sits between a serial front-end (bit stream plus valid) and a word-wide consumer.

Parameters:
DATA_WIDTH, 4, word width in bits; legal values are >= 2.
MSB_FIRST, 1, 1 means the first received bit lands in dout[DATA_WIDTH-1]; 0 means it lands in dout[0].

Ports:
clk  in  1  rising-edge clock; the only clock.
reset  in  1  synchronous, active-high reset.
din  in  1  serial data bit.
din_valid  in  1  din is sampled on this edge.
sof  in  1  start of frame; qualified only when din_valid=1.
dout  out  DATA_WIDTH  assembled word (output register).
dout_valid  out  1  dout holds an unconsumed word.
dout_ready  in  1  consumer accepts dout on this edge when dout_valid=1.
busy  out  1  partial word in progress (bit count != 0).
overflow  out  1  sticky: a completed word was dropped.
ovf_clr  in  1  clears overflow.

Behaviour:
- Reset (synchronous, active-high), sampled on a clk edge with reset=1:
  - Shift register, bit count, dout, dout_valid, busy and overflow all go to 0.
  - A partial word is discarded; it is not reported.
  - Reset has priority over every other input.
- Bit count:
  - Width is $clog2(DATA_WIDTH).
  - Advances only on a din_valid edge; holds when din_valid=0.
- Shift datapath, on a din_valid edge:
  - MSB_FIRST=1: sr <= {sr[W-2:0], din}.
  - MSB_FIRST=0: sr <= {din, sr[W-1:1]}.
- FSM with two states, encoded by the bit count:
  - IDLE (cnt=0): on din_valid, go to ASSEMBLE with cnt=1.
  - ASSEMBLE: on din_valid, cnt++. On the bit where cnt=W-1, the word completes, cnt wraps to 0 and the FSM returns to IDLE.
- sof handling:
  - sof with din_valid: the count restarts, this bit becomes bit 0 of a new word, and any partial word is silently dropped.
  - sof without din_valid: ignored.
- Word completion:
  - The completed word (old sr combined with the current din) loads into dout on the same edge.
  - dout_valid=1 from the next cycle, so latency is 1 cycle after the last bit is sampled.
- Output handshake:
  - A transfer occurs on an edge where dout_valid && dout_ready.
  - dout and dout_valid stay stable until that transfer.
  - After a transfer with no new completion, dout_valid drops to 0 and dout keeps its last value.
- Simultaneous transfer and completion: the new word loads and dout_valid stays 1, so full throughput is one word per DATA_WIDTH valid bits.
- Completion while dout_valid=1 and dout_ready=0:
  - The new word is dropped and dout is unchanged.
  - overflow is set to 1 on the next edge.
  - The bit count still wraps, so word alignment is preserved.
- ovf_clr:
  - Clears overflow on the next edge.
  - If ovf_clr and a new overflow event occur on the same edge, overflow is set (set wins).
- busy = (cnt != 0), registered.
- dout_ready is a don't-care when dout_valid=0.

Decomposition:
- Package s2p_pkg holds:
  - typedef enum {S_IDLE, S_ASSEMBLE} s2p_state_e;
  - function cnt_width(W) returning $clog2(W).
- Sub-module s2p_shift_core:
  - Parameterised DATA_WIDTH and MSB_FIRST.
  - Inputs: clk, reset, shift_en, din. Output: sr.
  - Pure shift register, no counting.
- s2p_frame_ctrl owns the counter, FSM, output register and overflow logic.

Test Plan:
1. W=4, MSB_FIRST=1, dout_ready=1; din 1,0,1,1 with din_valid on 4 consecutive edges -> dout=4'b1011, dout_valid=1 for exactly one cycle, starting the cycle after the 4th bit; busy=1 during bits 2-4 and 0 after.
2. Same bits with din_valid low for 3 cycles between bits 2 and 3 -> dout=4'b1011; busy held at 1 through the gap.
3. dout_ready=0; send words 1011 then 0110 -> dout stays 1011 with dout_valid=1; overflow=1 after the 8th bit. Pulse ovf_clr -> overflow=0. Raise dout_ready -> one transfer, then dout_valid=0.
4. Send 1,1, then sof=1 with bits 0,1,1,0 -> a single word dout=4'b0110; no overflow.
5. Assert reset after 2 bits, then send 1,0,0,1 -> all outputs 0 during reset, then dout=4'b1001.
6. MSB_FIRST=0; bits 1,0,1,1 -> dout=4'b1101. Back-to-back words with dout_ready=1 and completion on the transfer edge -> dout_valid stays 1, no overflow.

Source files
------------

// File: rtl/s2p_pkg.sv
// Shared types and helpers for the serial-to-parallel frame controller.
package s2p_pkg;

    typedef enum logic {
        S_IDLE     = 1'b0,
        S_ASSEMBLE = 1'b1
    } s2p_state_e;

    function automatic int unsigned cnt_width(input int unsigned w);
        return $clog2(w);
    endfunction

endpackage

// File: rtl/s2p_shift_core.sv
// Plain serial shift register; bit order selected by MSB_FIRST.
module s2p_shift_core
    import s2p_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 4,
    parameter bit          MSB_FIRST  = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  shift_en,
    input  logic                  din,
    output logic [DATA_WIDTH-1:0] sr
);

    logic [DATA_WIDTH-1:0] sr_q, sr_d;

    always_comb begin
        sr_d = sr_q;
        if (shift_en) begin
            if (MSB_FIRST) sr_d = {sr_q[DATA_WIDTH-2:0], din};
            else           sr_d = {din, sr_q[DATA_WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) sr_q <= '0;
        else       sr_q <= sr_d;
    end

    assign sr = sr_q;

endmodule

// File: rtl/s2p_frame_ctrl.sv
// Bit counter / framing FSM, single-entry valid/ready output register and
// sticky overflow around the s2p_shift_core datapath.
module s2p_frame_ctrl
    import s2p_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 4,
    parameter bit          MSB_FIRST  = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  din,
    input  logic                  din_valid,
    input  logic                  sof,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  dout_valid,
    input  logic                  dout_ready,
    output logic                  busy,
    output logic                  overflow,
    input  logic                  ovf_clr
);

    localparam int unsigned    CW       = cnt_width(DATA_WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(DATA_WIDTH - 1);

    s2p_state_e            state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic                  dout_valid_q, dout_valid_d;
    logic                  busy_q, busy_d;
    logic                  ovf_q, ovf_d;
    logic                  complete;
    logic [DATA_WIDTH-1:0] sr;
    logic [DATA_WIDTH-1:0] word;

    s2p_shift_core #(
        .DATA_WIDTH (DATA_WIDTH),
        .MSB_FIRST  (MSB_FIRST)
    ) u_shift (
        .clk      (clk),
        .reset    (reset),
        .shift_en (din_valid),
        .din      (din),
        .sr       (sr)
    );

    // Completed word is the value the shift register takes on this edge.
    assign word = MSB_FIRST ? {sr[DATA_WIDTH-2:0], din} : {din, sr[DATA_WIDTH-1:1]};

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        complete = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (din_valid) begin
                    cnt_d   = CW'(1);
                    state_d = S_ASSEMBLE;
                end
            end
            S_ASSEMBLE: begin
                if (din_valid) begin
                    if (sof) begin
                        cnt_d = CW'(1);
                    end else if (cnt_q == CNT_LAST) begin
                        cnt_d    = '0;
                        complete = 1'b1;
                        state_d  = S_IDLE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (cnt_d != '0);
    end

    always_comb begin
        dout_d       = dout_q;
        dout_valid_d = dout_valid_q;
        ovf_d        = ovf_q;
        if (dout_valid_q && dout_ready) dout_valid_d = 1'b0;
        if (ovf_clr) ovf_d = 1'b0;
        // A blocked completion drops the word but must win over ovf_clr.
        if (complete) begin
            if (dout_valid_q && !dout_ready) begin
                ovf_d = 1'b1;
            end else begin
                dout_d       = word;
                dout_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            ovf_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            busy_q       <= busy_d;
            ovf_q        <= ovf_d;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign busy       = busy_q;
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_s2p_frame_ctrl.sv
// Directed bench: cycle table for the MSB-first instance, plus a hand
// sequence for LSB-first ordering and back-to-back transfers.
module tb_s2p_frame_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b0, din = 1'b0, din_valid = 1'b0, sof = 1'b0;
    logic       dout_ready = 1'b0, ovf_clr = 1'b0;
    logic [3:0] dout_m, dout_l;
    logic       v_m, v_l, busy_m, busy_l, ovf_m, ovf_l;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    s2p_frame_ctrl #(.DATA_WIDTH(4), .MSB_FIRST(1'b1)) dut_m (
        .clk(clk), .reset(reset), .din(din), .din_valid(din_valid), .sof(sof),
        .dout(dout_m), .dout_valid(v_m), .dout_ready(dout_ready),
        .busy(busy_m), .overflow(ovf_m), .ovf_clr(ovf_clr)
    );

    s2p_frame_ctrl #(.DATA_WIDTH(4), .MSB_FIRST(1'b0)) dut_l (
        .clk(clk), .reset(reset), .din(din), .din_valid(din_valid), .sof(sof),
        .dout(dout_l), .dout_valid(v_l), .dout_ready(dout_ready),
        .busy(busy_l), .overflow(ovf_l), .ovf_clr(ovf_clr)
    );

    typedef struct {
        logic       rst, d, dv, s, rdy, clr;
        logic [3:0] e_dout;
        logic       e_v, e_busy, e_ovf;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rst, d, dv, s, rdy, clr,
                       input logic [3:0] ed, input logic ev, eb, eo);
        vec_t v;
        v.rst = rst; v.d = d; v.dv = dv; v.s = s; v.rdy = rdy; v.clr = clr;
        v.e_dout = ed; v.e_v = ev; v.e_busy = eb; v.e_ovf = eo;
        vecs.push_back(v);
    endtask

    task automatic step(input logic rst, d, dv, s, rdy, clr);
        @(negedge clk);
        reset = rst; din = d; din_valid = dv; sof = s; dout_ready = rdy; ovf_clr = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic chk4(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    initial begin
        // rst din dv sof rdy clr | dout v busy ovf
        add(1,0,0,0,0,0, 4'b0000,0,0,0);
        add(1,0,0,0,0,0, 4'b0000,0,0,0);
        // basic word 1011
        add(0,1,1,0,1,0, 4'b0000,0,1,0);
        add(0,0,1,0,1,0, 4'b0000,0,1,0);
        add(0,1,1,0,1,0, 4'b0000,0,1,0);
        add(0,1,1,0,1,0, 4'b1011,1,0,0);
        add(0,0,0,0,1,0, 4'b1011,0,0,0);
        // gap between bits 2 and 3, including a sof without din_valid
        add(0,1,1,0,1,0, 4'b1011,0,1,0);
        add(0,0,1,0,1,0, 4'b1011,0,1,0);
        add(0,1,0,0,1,0, 4'b1011,0,1,0);
        add(0,0,0,1,1,0, 4'b1011,0,1,0);
        add(0,1,0,0,1,0, 4'b1011,0,1,0);
        add(0,1,1,0,1,0, 4'b1011,0,1,0);
        add(0,1,1,0,1,0, 4'b1011,1,0,0);
        add(0,0,0,0,1,0, 4'b1011,0,0,0);
        // overflow: 1011 held, 0110 dropped
        add(0,1,1,0,0,0, 4'b1011,0,1,0);
        add(0,0,1,0,0,0, 4'b1011,0,1,0);
        add(0,1,1,0,0,0, 4'b1011,0,1,0);
        add(0,1,1,0,0,0, 4'b1011,1,0,0);
        add(0,0,1,0,0,0, 4'b1011,1,1,0);
        add(0,1,1,0,0,0, 4'b1011,1,1,0);
        add(0,1,1,0,0,0, 4'b1011,1,1,0);
        add(0,0,1,0,0,0, 4'b1011,1,0,1);
        add(0,0,0,0,0,1, 4'b1011,1,0,0);
        add(0,0,0,0,0,0, 4'b1011,1,0,0);
        add(0,0,0,0,1,0, 4'b1011,0,0,0);
        add(0,0,0,0,1,0, 4'b1011,0,0,0);
        // sof realigns: 1,1 dropped, word 0110
        add(0,1,1,0,1,0, 4'b1011,0,1,0);
        add(0,1,1,0,1,0, 4'b1011,0,1,0);
        add(0,0,1,1,1,0, 4'b1011,0,1,0);
        add(0,1,1,0,1,0, 4'b1011,0,1,0);
        add(0,1,1,0,1,0, 4'b1011,0,1,0);
        add(0,0,1,0,1,0, 4'b0110,1,0,0);
        add(0,0,0,0,1,0, 4'b0110,0,0,0);
        // reset mid-word with every other input active, then 1001
        add(0,1,1,0,1,0, 4'b0110,0,1,0);
        add(0,0,1,0,1,0, 4'b0110,0,1,0);
        add(1,1,1,1,1,0, 4'b0000,0,0,0);
        add(0,1,1,0,1,0, 4'b0000,0,1,0);
        add(0,0,1,0,1,0, 4'b0000,0,1,0);
        add(0,0,1,0,1,0, 4'b0000,0,1,0);
        add(0,1,1,0,1,0, 4'b1001,1,0,0);
        // overflow set beats ovf_clr on the same edge
        add(0,0,1,0,0,0, 4'b1001,1,1,0);
        add(0,0,1,0,0,0, 4'b1001,1,1,0);
        add(0,0,1,0,0,0, 4'b1001,1,1,0);
        add(0,1,1,0,0,1, 4'b1001,1,0,1);
        add(0,0,0,0,1,1, 4'b1001,0,0,0);

        foreach (vecs[i]) begin
            step(vecs[i].rst, vecs[i].d, vecs[i].dv, vecs[i].s, vecs[i].rdy, vecs[i].clr);
            chk4($sformatf("v%0d dout", i), dout_m, vecs[i].e_dout);
            chk1($sformatf("v%0d dout_valid", i), v_m, vecs[i].e_v);
            chk1($sformatf("v%0d busy", i), busy_m, vecs[i].e_busy);
            chk1($sformatf("v%0d overflow", i), ovf_m, vecs[i].e_ovf);
        end

        // LSB-first ordering and a completion coinciding with a transfer
        step(1,0,0,0,0,0);
        chk4("lsb reset dout", dout_l, 4'b0000);
        chk1("lsb reset valid", v_l, 1'b0);
        step(0,1,1,0,1,0);
        step(0,0,1,0,1,0);
        step(0,1,1,0,1,0);
        step(0,1,1,0,1,0);
        chk4("lsb word A", dout_l, 4'b1101);
        chk1("lsb word A valid", v_l, 1'b1);
        chk4("msb word A", dout_m, 4'b1011);
        step(0,0,1,0,0,0);
        step(0,0,1,0,0,0);
        step(0,1,1,0,0,0);
        chk1("lsb A held valid", v_l, 1'b1);
        chk4("lsb A held dout", dout_l, 4'b1101);
        step(0,0,1,0,1,0);
        chk4("lsb word B", dout_l, 4'b0100);
        chk1("lsb word B valid", v_l, 1'b1);
        chk1("lsb B no overflow", ovf_l, 1'b0);
        chk4("msb word B", dout_m, 4'b0010);
        chk1("msb B no overflow", ovf_m, 1'b0);
        step(0,1,1,0,1,0);
        chk1("lsb B consumed", v_l, 1'b0);
        step(0,1,1,0,1,0);
        step(0,1,1,0,1,0);
        step(0,0,1,0,1,0);
        chk4("lsb word C", dout_l, 4'b0111);
        chk4("msb word C", dout_m, 4'b1110);
        chk1("lsb word C valid", v_l, 1'b1);
        step(0,0,0,0,1,0);
        chk1("lsb C consumed", v_l, 1'b0);
        chk4("lsb C dout kept", dout_l, 4'b0111);
        chk1("lsb final overflow", ovf_l, 1'b0);
        chk1("lsb final busy", busy_l, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
